// File: rtl/temp_pkg.sv
// temp_pkg: shared definitions for the SPI temperature front end and the
// display block downstream of it.
//   - state_t        : reader FSM states
//   - FRAME_BITS     : sensor frame length (MSB first)
//   - TEMP_MSB/LSB   : position of the signed temperature field in a frame
//   - ALARM_TH_DEFAULT : over-temperature threshold, 0.0625 degC LSBs
//   - temp_field()   : extracts the temperature field from a raw frame
package temp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam int FRAME_BITS = 16;
   localparam int TEMP_MSB   = 15;
   localparam int TEMP_LSB   = 3;
   localparam int TEMP_W     = TEMP_MSB - TEMP_LSB + 1;

   // 800 * 0.0625 degC = 50.0 degC
   localparam logic signed [TEMP_W-1:0] ALARM_TH_DEFAULT = 13'sd800;

   // Pure slice: no sign extension, no scaling.
   function automatic logic [TEMP_W-1:0] temp_field(input logic [FRAME_BITS-1:0] f);
      return f[TEMP_MSB:TEMP_LSB];
   endfunction

endpackage

// File: rtl/temp_spi_reader_if.sv
// temp_spi_reader_if: request/result and sensor-pin bundle of the reader.
//   start : conversion request (to reader)
//   sdo   : sensor serial data (to reader)
//   cs    : sensor chip select, active low (from reader)
//   sclk  : SPI clock, idle low (from reader)
//   busy  : frame or CS-high gap in progress (from reader)
//   valid : one-cycle pulse, new result on frame/temp/alarm (from reader)
//   frame : last raw 16-bit frame
//   temp  : signed 13-bit temperature field of frame
//   alarm : temp >= threshold
// Modports: slave = reader side, master = controller/sensor side.
interface temp_spi_reader_if;
   import temp_pkg::*;

   logic                  start;
   logic                  sdo;
   logic                  cs;
   logic                  sclk;
   logic                  busy;
   logic                  valid;
   logic [FRAME_BITS-1:0] frame;
   logic [TEMP_W-1:0]     temp;
   logic                  alarm;

   modport slave (
      input  start, sdo,
      output cs, sclk, busy, valid, frame, temp, alarm
   );

   modport master (
      output start, sdo,
      input  cs, sclk, busy, valid, frame, temp, alarm
   );

endinterface

// File: rtl/spi_half_tick.sv
// spi_half_tick: half-period timer for the SPI reader.
//   clk, rst : clock, synchronous active-high reset
//   restart  : reload the counter (asserted by the FSM on every state entry)
//   tick     : one-cycle pulse on the last cycle of each CLK_DIV-cycle period
// The counter reloads itself after each tick, so a state that lasts several
// half-periods (the shift phase) sees a tick every CLK_DIV cycles.
module spi_half_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int              CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]   RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] count_reg;

   assign tick = (count_reg == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= RELOAD;
      end else if (restart || tick) begin
         count_reg <= RELOAD;
      end else begin
         count_reg <= count_reg - CW'(1);
      end
   end

endmodule

// File: rtl/temp_spi_reader.sv
// temp_spi_reader: reads one 16-bit frame (SPI mode 0, MSB first) from a
// temperature sensor per request and presents the raw frame, its signed
// 13-bit temperature field and an over-temperature flag.
//   clk  : system clock
//   rst  : synchronous reset, active high (aborts any frame in progress)
//   bus  : temp_spi_reader_if.slave (start/sdo in; cs, sclk, busy, valid,
//          frame, temp, alarm out)
// Parameters: CLK_DIV = clk cycles per sclk half-period (>= 2),
//             ALARM_TH = signed alarm threshold in 0.0625 degC LSBs.
//
// All pin/status outputs are registered from the *current* FSM state, so
// they trail the state register by one cycle. That lag is uniform, so the
// relative timing between cs, sclk, busy and valid matches the state
// durations exactly: cs falls one cycle after start is accepted and every
// phase lasts CLK_DIV cycles as seen on the pins.
module temp_spi_reader
   import temp_pkg::*;
#(
   parameter int                        CLK_DIV  = 4,
   parameter logic signed [TEMP_W-1:0]  ALARM_TH = ALARM_TH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   temp_spi_reader_if.slave      bus
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   state_t                state_reg, state_next;
   logic                  phase_reg, phase_next;      // 0 = sclk low half, 1 = high half
   logic [3:0]            bit_cnt_reg, bit_cnt_next;
   logic                  restart;
   logic                  tick;

   logic                  cs_reg, cs_next;
   logic                  sclk_reg, sclk_next;
   logic                  busy_reg, busy_next;
   logic                  valid_reg;
   logic                  hold_done_reg;
   logic                  shift_en;

   logic [FRAME_BITS-1:0] shift_reg, shift_next;
   logic [FRAME_BITS-1:0] frame_reg;
   logic [TEMP_W-1:0]     temp_reg;
   logic                  alarm_reg;
   logic [TEMP_W-1:0]     new_temp;

   spi_half_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_half_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         phase_reg   <= 1'b0;
         bit_cnt_reg <= 4'd0;
      end else begin
         state_reg   <= state_next;
         phase_reg   <= phase_next;
         bit_cnt_reg <= bit_cnt_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and next values of the registered pin outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      phase_next   = phase_reg;
      bit_cnt_next = bit_cnt_reg;

      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               state_next   = ST_SHIFT;
               phase_next   = 1'b0;
               bit_cnt_next = 4'd0;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (!phase_reg) begin
                  phase_next = 1'b1;
               end else begin
                  phase_next = 1'b0;
                  if (bit_cnt_reg == LAST_BIT) begin
                     state_next = ST_HOLD;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tick) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Every state entry starts a fresh CLK_DIV period.
      restart = (state_next != state_reg);

      cs_next   = !((state_reg == ST_SETUP) || (state_reg == ST_SHIFT) ||
                    (state_reg == ST_HOLD));
      sclk_next = (state_reg == ST_SHIFT) && phase_reg;
      busy_next = (state_reg != ST_IDLE);

      // Capture sdo on exactly the edge that drives the sclk pin 0->1.
      shift_en  = sclk_next && !sclk_reg;
   end

   // Shift register: bit 0 takes sdo, every other bit takes its neighbour.
   generate
      for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_shift
         if (gi == 0) begin : g_lsb
            assign shift_next[gi] = shift_en ? bus.sdo : shift_reg[gi];
         end else begin : g_upper
            assign shift_next[gi] = shift_en ? shift_reg[gi-1] : shift_reg[gi];
         end
      end
   endgenerate

   assign new_temp = temp_field(shift_reg);

   // ---------------------------------------------------------------------
   // Datapath and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_reg        <= 1'b1;
         sclk_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         valid_reg     <= 1'b0;
         hold_done_reg <= 1'b0;
         shift_reg     <= '0;
         frame_reg     <= '0;
         temp_reg      <= '0;
         alarm_reg     <= 1'b0;
      end else begin
         cs_reg        <= cs_next;
         sclk_reg      <= sclk_next;
         busy_reg      <= busy_next;
         shift_reg     <= shift_next;
         // HOLD ends one cycle before cs rises on the pin; results load and
         // valid pulses together with the cs rise.
         hold_done_reg <= (state_reg == ST_HOLD) && tick;
         valid_reg     <= hold_done_reg;
         if (hold_done_reg) begin
            frame_reg <= shift_reg;
            temp_reg  <= new_temp;
            alarm_reg <= ($signed(new_temp) >= ALARM_TH);
         end
      end
   end

   assign bus.cs    = cs_reg;
   assign bus.sclk  = sclk_reg;
   assign bus.busy  = busy_reg;
   assign bus.valid = valid_reg;
   assign bus.frame = frame_reg;
   assign bus.temp  = temp_reg;
   assign bus.alarm = alarm_reg;

endmodule

// File: doc/temp_spi_reader.md
# temp_spi_reader

Serial front end for the temperature subsystem: clocks one 16-bit frame out of an SPI temperature sensor (mode 0, MSB first) on request, and presents the raw frame, the 13-bit signed temperature field and an over-temperature flag to the downstream display/LED logic. It sits directly upstream of the temperature display block and owns the sensor-side `cs`, `sclk` and serial-data pins.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `sclk` half-period; legal range ≥ 2.
- `ALARM_TH`, 13'sd800: signed alarm threshold in 0.0625 °C LSBs (800 = 50.0 °C).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  conversion request; sampled only in IDLE.
- `sdo`  in  1  sensor serial data (sensor→FPGA).
- `cs`  out  1  sensor chip select, active low.
- `sclk`  out  1  SPI clock, idle low.
- `busy`  out  1  high while a frame or the CS-high gap is in progress.
- `valid`  out  1  one-cycle pulse: new result on outputs.
- `frame`  out  16  last complete raw frame.
- `temp`  out  13  signed temperature `frame[15:3]`.
- `alarm`  out  1  `temp >= ALARM_TH` (signed compare), updated with `valid`.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: `cs`=1, `sclk`=0, `busy`=0. `start`=1 → SETUP; `cs` falls and `busy` rises on the next edge.
- SETUP: `cs` low for CLK_DIV cycles with `sclk` low → SHIFT.
- SHIFT: 16 bits. Per bit: `sclk` low for CLK_DIV cycles, then high for CLK_DIV cycles. On the clk edge that drives `sclk` 0→1, `sdo` is shifted into bit 0 of the shift register (MSB arrives first). After the 16th high phase, `sclk` returns low → HOLD.
- HOLD: `sclk` low, `cs` low for CLK_DIV cycles. Then `cs` rises, `frame`/`temp`/`alarm` load, and `valid` pulses on that same edge → GAP.
- GAP: `cs` high for CLK_DIV cycles (minimum CS-high time). Then → IDLE, `busy` falls.
- `start` while `busy`=1 is ignored. There is no queuing.
- `start` held high re-triggers on the first IDLE cycle, giving back-to-back frames.
- Arithmetic: half-period counter runs 0..CLK_DIV-1, sized `$clog2(CLK_DIV)`; bit counter runs 0..15 (4 bits), no wrap beyond 15. `temp` is a pure slice, with no sign extension or scaling.
- Reset values: `cs`=1, `sclk`=0, `busy`=0, `valid`=0, `frame`=0, `temp`=0, `alarm`=0, state IDLE.
- `rst` mid-frame aborts on the next edge: `cs`=1, `sclk`=0, no `valid`, and previous results are cleared to 0.

## Timing
- Start accepted on edge T0. `cs`=0 from T0+1.
- First `sclk` rise at T0+1+2·CLK_DIV (SETUP plus the bit-0 low phase).
- `cs` is low for exactly 34·CLK_DIV cycles.
- `valid` pulses at T0+1+34·CLK_DIV.
- `busy` falls CLK_DIV cycles after `valid`.
- Minimum start-to-start period is 35·CLK_DIV+1 cycles (CLK_DIV=4: 141).
- All outputs are registered; no combinational path from `sdo` or `start` to any output.

## Structure
- Shared package `temp_pkg`:
  - state enum (`ST_IDLE`, `ST_SETUP`, `ST_SHIFT`, `ST_HOLD`, `ST_GAP`);
  - `FRAME_BITS`=16, `TEMP_MSB`=15, `TEMP_LSB`=3;
  - the `ALARM_TH` default constant, shared with the display block.
- Sub-module `spi_half_tick`: the CLK_DIV down-counter. It emits a one-cycle `tick` at the end of each half-period and is restarted by the FSM on every state entry.
- The FSM, shift register and output registers live in the top module.

## Test plan
- Reset then idle: with `rst`=1 for 3 cycles, `cs`=1, `sclk`=0, `busy`=0, `valid`=0, `frame`=0. With `rst` released and `start`=0 for 200 cycles, no output moves.
- Positive reading (CLK_DIV=4): sensor model drives 0x0C80 → `valid` at T0+137; `frame`=0x0C80, `temp`=0x190 (+25.0 °C), `alarm`=0; exactly 16 `sclk` rises counted while `cs`=0.
- Negative reading and alarm:
  - frame 0xF380 → `temp`=0x1E70 (−25.0 °C), `alarm`=0 (signed compare);
  - frame 0x1900 → `temp`=0x320, `alarm`=1 (boundary, equal to threshold).
- Start during busy: pulse `start` again at T0+50 → ignored; exactly one `valid`; `busy` falls at T0+141.
- Held start: `start` tied high with frames 0xAAA8 then 0x5550 → two `valid` pulses 141 cycles apart carrying those values in order; `cs` high ≥ 4 cycles between frames.
- Reset mid-frame: `rst` asserted at T0+60 → `cs`=1 and `sclk`=0 on the next edge, no `valid`, `frame`=0. A new start then completes normally.
